// File: rtl/serial_unsigned_compare_unit_if.sv
// rtl/serial_unsigned_compare_unit_if.sv - operand load/control and result bundle for the serial comparator
interface serial_unsigned_compare_unit_if #(
  parameter int WIDTH = 32
);
  logic             load;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             op;
  logic             a_bit;
  logic             b_bit;
  logic             L;
  logic             E;
  logic             G;
  logic             done;

  modport master (
    output load, a_in, b_in, op,
    input  a_bit, b_bit, L, E, G, done
  );

  modport slave (
    input  load, a_in, b_in, op,
    output a_bit, b_bit, L, E, G, done
  );
endinterface

// File: rtl/serial_unsigned_compare_unit.sv
// rtl/serial_unsigned_compare_unit.sv - bit-serial LSB-first unsigned magnitude comparator
// Operands are shifted out one bit per enabled cycle; the latest differing bit pair wins.
module serial_unsigned_compare_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  serial_unsigned_compare_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EQ = 2'b00,
    ST_LT = 2'b01,
    ST_GT = 2'b10
  } cmp_state_t;

  cmp_state_t       r_state;
  cmp_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             w_step;

  // A compare step only happens while enabled, not loading, and bits remain.
  assign w_step = !bus.load && !bus.op && (r_cnt < CNT_W'(WIDTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (bus.load) begin
      r_a    <= bus.a_in;
      r_b    <= bus.b_in;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (w_step) begin
      r_a    <= {1'b0, r_a[WIDTH-1:1]};
      r_b    <= {1'b0, r_b[WIDTH-1:1]};
      r_cnt  <= r_cnt + CNT_W'(1);
      r_done <= (r_cnt == CNT_W'(WIDTH - 1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_EQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.load) begin
      w_state_nxt = ST_EQ;
    end else if (w_step) begin
      if (r_a[0] && !r_b[0]) begin
        w_state_nxt = ST_GT;
      end else if (!r_a[0] && r_b[0]) begin
        w_state_nxt = ST_LT;
      end
    end
  end

  always_comb begin
    bus.L     = 1'b0;
    bus.E     = 1'b0;
    bus.G     = 1'b0;
    bus.a_bit = r_a[0];
    bus.b_bit = r_b[0];
    bus.done  = r_done;
    case (r_state)
      ST_LT:   bus.L = 1'b1;
      ST_GT:   bus.G = 1'b1;
      default: bus.E = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_serial_unsigned_compare_unit.sv
// tb/tb_serial_unsigned_compare_unit.sv - directed bench with prefix-compare reference model
module tb_serial_unsigned_compare_unit;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  serial_unsigned_compare_unit_if #(.WIDTH(WIDTH)) bus ();

  serial_unsigned_compare_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: after k enabled cycles the result is the compare of the low k bits.
  longint unsigned m_a = 0;
  longint unsigned m_b = 0;
  int              m_k = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_a = 0;
      m_b = 0;
      m_k = 0;
    end else if (bus.load) begin
      m_a = longint'(bus.a_in);
      m_b = longint'(bus.b_in);
      m_k = 0;
    end else if (!bus.op && m_k < WIDTH) begin
      m_k = m_k + 1;
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    longint unsigned mask, la, lb;
    mask = (64'd1 << m_k) - 64'd1;
    la   = m_a & mask;
    lb   = m_b & mask;
    chk("model_L",     bus.L,     la < lb);
    chk("model_E",     bus.E,     la == lb);
    chk("model_G",     bus.G,     la > lb);
    chk("model_done",  bus.done,  m_k == WIDTH);
    chk("model_a_bit", bus.a_bit, 1'((m_a >> m_k) & 64'd1));
    chk("model_b_bit", bus.b_bit, 1'((m_b >> m_k) & 64'd1));
  end

  task automatic do_load(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic o);
    @(negedge clk);
    bus.load = 1'b1;
    bus.a_in = a;
    bus.b_in = b;
    bus.op   = o;
    @(negedge clk);
    bus.load = 1'b0;
    bus.op   = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.load = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;
    bus.op   = 1'b0;
    #1;
    chk("rst_L", bus.L, 1'b0);
    chk("rst_E", bus.E, 1'b1);
    chk("rst_G", bus.G, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    cycles(2);
    rst = 1'b1;

    cycles(40);
    chk("powerup_E", bus.E, 1'b1);

    do_load(32'hFFFFFFFF, 32'd123, 1'b0);
    cycles(WIDTH);
    chk("max_G", bus.G, 1'b1);
    chk("max_L", bus.L, 1'b0);
    chk("max_E", bus.E, 1'b0);
    chk("max_done", bus.done, 1'b1);
    bus.op = 1'b1;
    cycles(10);
    chk("max_hold_G", bus.G, 1'b1);
    bus.op = 1'b0;

    do_load(32'd5, 32'd9, 1'b0);
    cycles(1); chk("c1_E", bus.E, 1'b1);
    cycles(1); chk("c2_E", bus.E, 1'b1);
    cycles(1); chk("c3_G", bus.G, 1'b1);
    cycles(1); chk("c4_L", bus.L, 1'b1);
    cycles(27); chk("c31_done", bus.done, 1'b0);
    cycles(1);
    chk("c32_L", bus.L, 1'b1);
    chk("c32_done", bus.done, 1'b1);

    do_load(32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0);
    for (int i = 0; i < WIDTH; i++) begin
      cycles(1);
      chk("eq_E", bus.E, 1'b1);
    end
    chk("eq_done", bus.done, 1'b1);

    do_load(32'h80000000, 32'h7FFFFFFF, 1'b0);
    cycles(31);
    chk("msb_L31", bus.L, 1'b1);
    cycles(1);
    chk("msb_G32", bus.G, 1'b1);

    do_load(32'd1, 32'd0, 1'b0);
    cycles(10);
    bus.op = 1'b1;
    cycles(20);
    chk("frz_G", bus.G, 1'b1);
    chk("frz_done", bus.done, 1'b0);
    bus.op = 1'b0;
    cycles(21);
    chk("frz_done21", bus.done, 1'b0);
    cycles(1);
    chk("frz_done22", bus.done, 1'b1);
    chk("frz_G_final", bus.G, 1'b1);

    do_load(32'h0000F00F, 32'h0000F0F1, 1'b0);
    cycles(14);
    #2 rst = 1'b0;
    #1;
    chk("arst_L", bus.L, 1'b0);
    chk("arst_E", bus.E, 1'b1);
    chk("arst_G", bus.G, 1'b0);
    chk("arst_done", bus.done, 1'b0);
    chk("arst_a_bit", bus.a_bit, 1'b0);
    chk("arst_b_bit", bus.b_bit, 1'b0);
    cycles(1);
    rst = 1'b1;

    do_load(32'd3, 32'd7, 1'b1);
    chk("ldop_a_bit", bus.a_bit, 1'b1);
    cycles(WIDTH);
    chk("ldop_L", bus.L, 1'b1);
    chk("ldop_done", bus.done, 1'b1);

    cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
